// File: rtl/modbus_resp_tx_if.sv
// Request/status and UART byte-handshake bundle for modbus_resp_tx.
// slave: the response sequencer; master: slave core plus uart_byte_tx side.
interface modbus_resp_tx_if;
  logic        resp_start;
  logic        resp_exc;
  logic [7:0]  resp_func;
  logic [15:0] resp_addr;
  logic [15:0] resp_data;
  logic [7:0]  resp_exc_code;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        resp_done;
  logic        resp_err;

  modport slave (
    input  resp_start, resp_exc, resp_func, resp_addr, resp_data, resp_exc_code, tx_done,
    output tx_start, tx_data, busy, resp_done, resp_err
  );

  modport master (
    output resp_start, resp_exc, resp_func, resp_addr, resp_data, resp_exc_code, tx_done,
    input  tx_start, tx_data, busy, resp_done, resp_err
  );
endinterface

// File: rtl/modbus_resp_tx.sv
// Modbus RTU response sequencer: builds the reply, appends CRC-16/Modbus, paces bytes to the UART.
// Optional per-byte watchdog enabled by defining RESP_TIMEOUT_EN.
module modbus_resp_tx #(
  parameter logic [7:0]  ADDR        = 8'h01,
  parameter int unsigned TX_GAP      = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic              clk_in,
  input logic              rst_n_in,
  modbus_resp_tx_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StWait, StGap, StDone} state_e;
  typedef enum logic [1:0] {KindExc, KindRead, KindWrite} kind_e;

  state_e      state_q;
  kind_e       kind_q;
  logic [7:0]  func_q;
  logic [7:0]  code_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic [2:0]  idx_q;
  logic [15:0] crc_q;
  logic [2:0]  crc_cnt_q;
  logic [15:0] gap_cnt_q;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;
  logic        busy_q;
  logic        resp_done_q;
  logic [2:0]  frame_len;
  logic [7:0]  byte_sel;
  logic        last_byte;

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = busy_q;
  assign bus.resp_done = resp_done_q;

`ifdef RESP_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  logic        resp_err_q;
  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  function automatic logic [15:0] crc_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  always_comb begin
    case (kind_q)
      KindRead:  frame_len = 3'd5;
      KindWrite: frame_len = 3'd6;
      default:   frame_len = 3'd3;
    endcase
  end

  assign last_byte = (idx_q == frame_len + 3'd1);

  always_comb begin
    byte_sel = ADDR;
    if (idx_q == frame_len) begin
      byte_sel = crc_q[7:0];
    end else if (last_byte) begin
      byte_sel = crc_q[15:8];
    end else if (idx_q == 3'd1) begin
      byte_sel = func_q;
    end else if (idx_q != 3'd0) begin
      unique case (kind_q)
        KindRead: begin
          case (idx_q)
            3'd2:    byte_sel = 8'h02;
            3'd3:    byte_sel = data_q[15:8];
            default: byte_sel = data_q[7:0];
          endcase
        end
        KindWrite: begin
          case (idx_q)
            3'd2:    byte_sel = addr_q[15:8];
            3'd3:    byte_sel = addr_q[7:0];
            3'd4:    byte_sel = data_q[15:8];
            default: byte_sel = data_q[7:0];
          endcase
        end
        default: byte_sel = code_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      kind_q      <= KindExc;
      func_q      <= 8'h00;
      code_q      <= 8'h00;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      idx_q       <= 3'd0;
      crc_q       <= 16'hFFFF;
      crc_cnt_q   <= 3'd0;
      gap_cnt_q   <= 16'h0000;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      resp_done_q <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      to_cnt_q    <= 32'd0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      resp_done_q <= 1'b0;
`ifdef RESP_TIMEOUT_EN
      resp_err_q  <= 1'b0;
`endif
      // Remaining CRC bit steps run in the background while the UART shifts the byte out.
      if (crc_cnt_q != 3'd0) begin
        crc_q     <= crc_step(crc_q);
        crc_cnt_q <= crc_cnt_q - 3'd1;
      end
      case (state_q)
        StIdle: begin
          if (bus.resp_start) begin
            addr_q    <= bus.resp_addr;
            data_q    <= bus.resp_data;
            idx_q     <= 3'd0;
            crc_q     <= 16'hFFFF;
            crc_cnt_q <= 3'd0;
            busy_q    <= 1'b1;
            state_q   <= StLoad;
            if (bus.resp_exc) begin
              kind_q <= KindExc;
              func_q <= bus.resp_func | 8'h80;
              code_q <= bus.resp_exc_code;
            end else if (bus.resp_func == 8'h03) begin
              kind_q <= KindRead;
              func_q <= 8'h03;
            end else if (bus.resp_func == 8'h06) begin
              kind_q <= KindWrite;
              func_q <= 8'h06;
            end else begin
              kind_q <= KindExc;
              func_q <= bus.resp_func | 8'h80;
              code_q <= 8'h01;
            end
          end
        end
        StLoad: begin
          tx_data_q  <= byte_sel;
          tx_start_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          tx_start_q <= 1'b0;
          state_q    <= StWait;
`ifdef RESP_TIMEOUT_EN
          to_cnt_q   <= 32'd0;
`endif
          // Payload bytes only; the XOR and first shift share this cycle.
          if (idx_q < frame_len) begin
            crc_q     <= crc_step(crc_q ^ {8'h00, tx_data_q});
            crc_cnt_q <= 3'd7;
          end
        end
        StWait: begin
          if (bus.tx_done) begin
            if (last_byte) begin
              resp_done_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StDone;
            end else begin
              idx_q     <= idx_q + 3'd1;
              gap_cnt_q <= 16'h0000;
              state_q   <= StGap;
            end
          end
`ifdef RESP_TIMEOUT_EN
          else if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
            resp_err_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        StGap: begin
          if (gap_cnt_q == 16'(TX_GAP - 1)) begin
            state_q <= StLoad;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/modbus_resp_tx.md
Name: modbus_resp_tx

Overview:
- Response-frame sequencer for the Modbus RTU slave.
- Takes a parsed response request from the slave core: normal 0x03/0x06 reply or exception.
- Builds the byte stream, computes CRC-16/Modbus inline, and drives uart_byte_tx one byte at a time through its tx_start/tx_data/tx_done handshake.
- Sits between the request decode (frame_rx + register logic) and the UART transmitter.

Parameters:
- ADDR, 8'h01, slave address placed in byte 0 of every response.
- TX_GAP, 16, idle clk_in cycles between tx_done and the next tx_start (must be ≥1).
- TIMEOUT_CYC, 'd50000, cycles allowed per byte before abort (used only with the optional feature).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  reset
- resp_start  input  1  one-cycle request pulse; sampled only in IDLE
- resp_exc  input  1  1 = exception response
- resp_func  input  8  function code of the request (0x03 or 0x06)
- resp_addr  input  16  register address (echoed for 0x06)
- resp_data  input  16  register value (0x03 read value / 0x06 written value)
- resp_exc_code  input  8  exception code
- tx_done  input  1  byte-complete pulse from uart_byte_tx
- tx_start  output  1  one-cycle start pulse to uart_byte_tx
- tx_data  output  8  byte to transmit; stable from tx_start until the next load
- busy  output  1  high from accept to resp_done
- resp_done  output  1  one-cycle pulse after the last CRC byte completes
- resp_err  output  1  one-cycle abort pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset:
  - Asynchronous, active-low on rst_n_in; single clock clk_in.
  - On reset all outputs are 0, state is IDLE, CRC register is 16'hFFFF.
  - Reset mid-frame abandons the frame immediately; tx_start stays 0.
- Accept:
  - In IDLE, resp_start=1 latches all resp_* inputs into internal registers, sets busy=1 next cycle, and enters LOAD.
  - resp_start while busy is ignored.
- Frame formats (len excludes CRC):
  - exception: ADDR, resp_func|8'h80, resp_exc_code (len 3)
  - 0x03: ADDR, 8'h03, 8'h02, data_hi, data_lo (len 5)
  - 0x06: ADDR, 8'h06, addr_hi, addr_lo, data_hi, data_lo (len 6)
  - any other function with resp_exc=0: treated as exception with code 8'h01
  - Trailer: CRC low byte, then CRC high byte.
- State machine: IDLE -> LOAD -> SEND -> WAIT -> GAP -> LOAD ... -> DONE -> IDLE.
  - LOAD: select byte[idx] (idx 0..len+1) onto tx_data.
  - SEND: tx_start=1 for exactly one cycle. For payload bytes, start the CRC update on the same byte.
  - WAIT: hold until tx_done=1.
  - GAP: count TX_GAP cycles. If the byte just sent was the last (idx=len+1), go to DONE instead.
  - DONE: resp_done=1 and busy=0 for one cycle, then IDLE. resp_done is asserted the cycle after the final tx_done.
- CRC:
  - Polynomial 0xA001 reflected, init 0xFFFF.
  - Bit-serial, 8 clk_in cycles per byte, starting in SEND.
  - Must finish before tx_done; a UART byte is thousands of cycles long.
  - CRC bytes are not fed into the CRC.
  - The CRC register is reinitialised to 0xFFFF on every accept.
- tx_done arriving outside WAIT is ignored.

Optional Feature:
- Macro: RESP_TIMEOUT_EN
- Enabled:
  - A counter runs in WAIT and clears on entry to WAIT.
  - Reaching TIMEOUT_CYC without tx_done pulses resp_err for one cycle, sets busy=0, goes to IDLE, and never asserts resp_done.
- Disabled:
  - No counter is built; resp_err is constant 0; WAIT blocks indefinitely.

Test Plan:
- Reset held, toggle resp_start -> tx_start, busy, resp_done stay 0. After release, first accept works.
- resp_func=0x06, addr=0x0001, data=0x0005 -> UART loopback receives 01 06 00 01 00 05 18 09; resp_done pulses once after the 8th tx_done.
- resp_func=0x03, data=0x0001 -> bytes 01 03 02 00 01 79 84; no tx_start within TX_GAP cycles of any tx_done.
- resp_exc=1, func=0x03, code=0x02 -> bytes 01 83 02 C0 F1; busy high exactly from accept+1 to resp_done.
- Second resp_start pulsed mid-frame -> ignored, frame unchanged. rst_n_in low during byte 3 -> outputs 0 immediately; next request sends a full correct frame.
- RESP_TIMEOUT_EN defined, TIMEOUT_CYC=100, tx_done withheld -> resp_err pulse at 100 cycles in WAIT, busy=0, no resp_done.
